// File: rtl/graph_vertex_fetch_if.sv
// Bus bundle for graph_vertex_fetch: scheduler request/response, the two FIFO
// heads and both graph-memory read ports.
// slave  = the fetch block itself; master = scheduler plus graph memory side.
interface graph_vertex_fetch_if;
    logic [31:0] v_addr_in;
    logic        valid_in;
    logic        ready_out;

    logic [31:0] data_out;
    logic        data_valid_out;
    logic        pos_deq_in;
    logic        pos_full_out;
    logic        pos_empty_out;

    logic [31:0] neigh_fifo_out;
    logic        neigh_valid_out;
    logic        neigh_deq_in;
    logic        neigh_full_out;
    logic        neigh_empty_out;

    logic [31:0] mem_req_out;
    logic        mem_valid_out;
    logic [31:0] mem_data_in;
    logic        mem_valid_in;

    logic [31:0] mem_req_out2;
    logic        mem_valid_out2;
    logic [31:0] mem_data_in2;
    logic        mem_valid_in2;

    modport slave (
        input  v_addr_in, valid_in, pos_deq_in, neigh_deq_in,
        input  mem_data_in, mem_valid_in, mem_data_in2, mem_valid_in2,
        output ready_out,
        output data_out, data_valid_out, pos_full_out, pos_empty_out,
        output neigh_fifo_out, neigh_valid_out, neigh_full_out, neigh_empty_out,
        output mem_req_out, mem_valid_out, mem_req_out2, mem_valid_out2
    );

    modport master (
        output v_addr_in, valid_in, pos_deq_in, neigh_deq_in,
        output mem_data_in, mem_valid_in, mem_data_in2, mem_valid_in2,
        input  ready_out,
        input  data_out, data_valid_out, pos_full_out, pos_empty_out,
        input  neigh_fifo_out, neigh_valid_out, neigh_full_out, neigh_empty_out,
        input  mem_req_out, mem_valid_out, mem_req_out2, mem_valid_out2
    );
endinterface

// File: rtl/graph_vertex_fetch.sv
// Graph-traversal front end: fetches a vertex record over two graph-memory read
// ports, queues its position words and its (not yet visited) neighbour addresses.
// Optional feature macro: GVF_VISITED_FILTER_EN enables the visited bitmap and
// neighbour filtering; without it every neighbour is queued.

// First-word-fall-through FIFO with registered head and status flags.
module gvf_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         valid,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_next;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] head_next;
    logic             push_ok;
    logic             pop_ok;

    // Next pointer/count and the head word that will be visible after this edge.
    always_comb begin
        pop_ok    = pop && (count != '0);
        push_ok   = push && (count != CW'(DEPTH));
        rd_next   = pop_ok ? rd_ptr + PW'(1) : rd_ptr;
        cnt_next  = count + CW'(push_ok) - CW'(pop_ok);
        head_next = '0;
        if (cnt_next != '0) begin
            head_next = (push_ok && (wr_ptr == rd_next)) ? din : store[rd_next];
        end
    end

    // Pointers, occupancy and registered status outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
            valid  <= 1'b0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            rd_ptr <= rd_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            count <= cnt_next;
            head  <= head_next;
            valid <= (cnt_next != '0);
            empty <= (cnt_next == '0);
            full  <= (cnt_next == CW'(DEPTH));
        end
    end

    // Storage array; contents are only observed through the head register.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            store[wr_ptr] <= din;
        end
    end
endmodule

module graph_vertex_fetch #(
    parameter int unsigned DIM        = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned VADDR_BITS = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    graph_vertex_fetch_if.slave bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned KW = $clog2(DIM + 1);

    typedef enum logic [1:0] {IDLE, FETCH, NEIGH, DRAIN} state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   v_base;
    logic [KW-1:0] a_issued;
    logic          cnt_issued;
    logic          n_got;
    logic [31:0]   n_cnt;
    logic [31:0]   b_idx;
    logic [CW-1:0] a_out;
    logic [CW-1:0] b_out;

    logic          accept_c;
    logic          issue_a_c;
    logic          issue_b_c;
    logic [31:0]   b_addr_c;
    logic          resp_a_c;
    logic          resp_b_c;
    logic          cnt_resp_c;
    logic          nb_keep_c;
    logic          nb_push_c;

    logic [31:0]   mem_req_a;
    logic          mem_vld_a;
    logic [31:0]   mem_req_b;
    logic          mem_vld_b;
    logic          ready_q;

    logic [31:0]   pos_head;
    logic          pos_valid;
    logic          pos_empty;
    logic          pos_full;
    logic [CW-1:0] pos_cnt;
    logic [31:0]   neigh_head;
    logic          neigh_valid;
    logic          neigh_empty;
    logic          neigh_full;
    logic [CW-1:0] neigh_cnt;

    // Responses are only meaningful while a fetch is in progress; stragglers are dropped.
    assign resp_a_c   = bus.mem_valid_in  && (state != IDLE) && (a_out != '0);
    assign resp_b_c   = bus.mem_valid_in2 && (state != IDLE) && (b_out != '0);
    assign cnt_resp_c = resp_b_c && !n_got;
    assign nb_push_c  = resp_b_c && n_got && nb_keep_c;

`ifdef GVF_VISITED_FILTER_EN
    logic [2**VADDR_BITS-1:0] visited;

    assign nb_keep_c = !visited[bus.mem_data_in2[VADDR_BITS-1:0]];

    // Visited bitmap: marked by accepted requests and by every neighbour queued.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            visited <= '0;
        end else begin
            if (accept_c) begin
                visited[bus.v_addr_in[VADDR_BITS-1:0]] <= 1'b1;
            end
            if (nb_push_c) begin
                visited[bus.mem_data_in2[VADDR_BITS-1:0]] <= 1'b1;
            end
        end
    end
`else
    assign nb_keep_c = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle issue decisions, credit-gated against FIFO space.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        issue_a_c  = 1'b0;
        issue_b_c  = 1'b0;
        b_addr_c   = '0;
        case (state)
            IDLE: begin
                if (bus.valid_in) begin
                    accept_c   = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if ((a_issued < KW'(DIM)) &&
                    ((SW'(pos_cnt) + SW'(a_out)) < SW'(FIFO_DEPTH))) begin
                    issue_a_c = 1'b1;
                end
                if (!cnt_issued) begin
                    issue_b_c = 1'b1;
                    b_addr_c  = v_base + 32'(DIM);
                end
                if (n_got && (a_issued == KW'(DIM))) begin
                    state_next = (n_cnt == '0) ? DRAIN : NEIGH;
                end
            end
            NEIGH: begin
                if (b_idx == n_cnt) begin
                    state_next = DRAIN;
                end else if ((SW'(neigh_cnt) + SW'(b_out)) < SW'(FIFO_DEPTH)) begin
                    issue_b_c = 1'b1;
                    b_addr_c  = v_base + 32'(DIM) + 32'd1 + b_idx;
                end
            end
            DRAIN: begin
                if ((a_out == '0) && (b_out == '0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request bookkeeping: issue progress, neighbour count and outstanding credits.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            v_base     <= '0;
            a_issued   <= '0;
            cnt_issued <= 1'b0;
            n_got      <= 1'b0;
            n_cnt      <= '0;
            b_idx      <= '0;
            a_out      <= '0;
            b_out      <= '0;
        end else begin
            if (accept_c) begin
                v_base     <= bus.v_addr_in;
                a_issued   <= '0;
                cnt_issued <= 1'b0;
                n_got      <= 1'b0;
                n_cnt      <= '0;
                b_idx      <= '0;
            end
            if (issue_a_c) begin
                a_issued <= a_issued + KW'(1);
            end
            if (issue_b_c) begin
                if (state == FETCH) begin
                    cnt_issued <= 1'b1;
                end else begin
                    b_idx <= b_idx + 32'd1;
                end
            end
            if (cnt_resp_c) begin
                n_got <= 1'b1;
                n_cnt <= bus.mem_data_in2;
            end
            a_out <= a_out + CW'(issue_a_c) - CW'(resp_a_c);
            b_out <= b_out + CW'(issue_b_c) - CW'(resp_b_c);
        end
    end

    // Registered memory request strobes/addresses and the ready flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_req_a <= '0;
            mem_vld_a <= 1'b0;
            mem_req_b <= '0;
            mem_vld_b <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            mem_vld_a <= issue_a_c;
            mem_vld_b <= issue_b_c;
            if (issue_a_c) begin
                mem_req_a <= v_base + 32'(a_issued);
            end
            if (issue_b_c) begin
                mem_req_b <= b_addr_c;
            end
            ready_q <= (state_next == IDLE);
        end
    end

    gvf_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_pos_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (resp_a_c),
        .din    (bus.mem_data_in),
        .pop    (bus.pos_deq_in),
        .head   (pos_head),
        .valid  (pos_valid),
        .empty  (pos_empty),
        .full   (pos_full),
        .count  (pos_cnt)
    );

    gvf_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_neigh_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (nb_push_c),
        .din    (bus.mem_data_in2),
        .pop    (bus.neigh_deq_in),
        .head   (neigh_head),
        .valid  (neigh_valid),
        .empty  (neigh_empty),
        .full   (neigh_full),
        .count  (neigh_cnt)
    );

    assign bus.ready_out       = ready_q;
    assign bus.data_out        = pos_head;
    assign bus.data_valid_out  = pos_valid;
    assign bus.pos_full_out    = pos_full;
    assign bus.pos_empty_out   = pos_empty;
    assign bus.neigh_fifo_out  = neigh_head;
    assign bus.neigh_valid_out = neigh_valid;
    assign bus.neigh_full_out  = neigh_full;
    assign bus.neigh_empty_out = neigh_empty;
    assign bus.mem_req_out     = mem_req_a;
    assign bus.mem_valid_out   = mem_vld_a;
    assign bus.mem_req_out2    = mem_req_b;
    assign bus.mem_valid_out2  = mem_vld_b;
endmodule

// File: tb/tb_graph_vertex_fetch.sv
// Bench for graph_vertex_fetch: 2-cycle graph memory model, randomized FIFO
// draining, and a list-level reference model of fetch and neighbour filtering.
module tb_graph_vertex_fetch;
    localparam int unsigned DIM   = 4;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned VB    = 8;
    localparam int          TMO   = 600;

    bit   clk_in;
    logic rst_in;

    graph_vertex_fetch_if bus();

    graph_vertex_fetch #(
        .DIM        (DIM),
        .FIFO_DEPTH (DEPTH),
        .VADDR_BITS (VB)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Graph memory: two read ports, fixed 2-cycle latency.
    logic [31:0] gmem [1024];
    bit          a_v1, a_v2, b_v1, b_v2;
    logic [31:0] a_d1, a_d2, b_d1, b_d2;

    always @(posedge clk_in) begin
        a_v1 <= bus.mem_valid_out;
        a_d1 <= gmem[bus.mem_req_out[9:0]];
        a_v2 <= a_v1;
        a_d2 <= a_d1;
        b_v1 <= bus.mem_valid_out2;
        b_d1 <= gmem[bus.mem_req_out2[9:0]];
        b_v2 <= b_v1;
        b_d2 <= b_d1;
    end

    assign bus.mem_valid_in  = a_v2;
    assign bus.mem_data_in   = a_d2;
    assign bus.mem_valid_in2 = b_v2;
    assign bus.mem_data_in2  = b_d2;

    int          n_cmp;
    int          n_bad;
    int          a_reqs;
    int          b_reqs;
    int          a0;
    int          b0;
    int          exp_n;
    bit          pos_pop_rand;
    int          pos_pop_once;
    bit          mvis [256];
    logic [31:0] got_pos[$];
    logic [31:0] got_neigh[$];
    logic [31:0] exp_pos[$];
    logic [31:0] exp_neigh[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    // Consumer side: random dequeues, popped-word capture and request counting.
    initial begin
        bus.pos_deq_in   = 1'b0;
        bus.neigh_deq_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (bus.mem_valid_out)  a_reqs++;
            if (bus.mem_valid_out2) b_reqs++;
            bus.pos_deq_in = pos_pop_rand ? ($urandom_range(0, 2) != 0) : (pos_pop_once != 0);
            if (pos_pop_once != 0) pos_pop_once--;
            bus.neigh_deq_in = ($urandom_range(0, 2) != 0);
            if (bus.pos_deq_in && bus.data_valid_out)     got_pos.push_back(bus.data_out);
            if (bus.neigh_deq_in && bus.neigh_valid_out) got_neigh.push_back(bus.neigh_fifo_out);
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_ready"},       32'(bus.ready_out),       32'd1);
        chk({tag, "_pos_valid"},   32'(bus.data_valid_out),  32'd0);
        chk({tag, "_pos_empty"},   32'(bus.pos_empty_out),   32'd1);
        chk({tag, "_pos_full"},    32'(bus.pos_full_out),    32'd0);
        chk({tag, "_pos_head"},    bus.data_out,             32'd0);
        chk({tag, "_nb_valid"},    32'(bus.neigh_valid_out), 32'd0);
        chk({tag, "_nb_empty"},    32'(bus.neigh_empty_out), 32'd1);
        chk({tag, "_nb_full"},     32'(bus.neigh_full_out),  32'd0);
        chk({tag, "_nb_head"},     bus.neigh_fifo_out,       32'd0);
        chk({tag, "_mem_vld_a"},   32'(bus.mem_valid_out),   32'd0);
        chk({tag, "_mem_vld_b"},   32'(bus.mem_valid_out2),  32'd0);
        chk({tag, "_mem_req_a"},   bus.mem_req_out,          32'd0);
        chk({tag, "_mem_req_b"},   bus.mem_req_out2,         32'd0);
    endtask

    // Builds the expected lists for vertex v from the memory image, then issues it.
    task automatic start_req(input logic [31:0] v, input bit busy);
        logic [31:0] addr;
        logic [31:0] w;
        int          cyc;
        exp_pos.delete();
        exp_neigh.delete();
        for (int k = 0; k < int'(DIM); k++) begin
            addr = v + 32'(k);
            exp_pos.push_back(gmem[addr[9:0]]);
        end
        addr  = v + 32'(DIM);
        exp_n = int'(gmem[addr[9:0]]);
`ifdef GVF_VISITED_FILTER_EN
        mvis[v[7:0]] = 1'b1;
`endif
        for (int i = 1; i <= exp_n; i++) begin
            addr = v + 32'(DIM) + 32'(i);
            w    = gmem[addr[9:0]];
`ifdef GVF_VISITED_FILTER_EN
            if (!mvis[w[7:0]]) begin
                mvis[w[7:0]] = 1'b1;
                exp_neigh.push_back(w);
            end
`else
            exp_neigh.push_back(w);
`endif
        end
        cyc = 0;
        while (!bus.ready_out && cyc < TMO) begin
            @(negedge clk_in);
            cyc++;
        end
        chk("ready_wait", 32'(cyc < TMO), 32'd1);
        got_pos.delete();
        got_neigh.delete();
        a0 = a_reqs;
        b0 = b_reqs;
        bus.v_addr_in = v;
        bus.valid_in  = 1'b1;
        @(negedge clk_in);
        bus.valid_in = 1'b0;
        chk("busy_after_accept", 32'(bus.ready_out), 32'd0);
        if (busy) begin
            repeat (2) @(negedge clk_in);
            bus.v_addr_in = 32'd55;
            bus.valid_in  = 1'b1;
            @(negedge clk_in);
            bus.valid_in = 1'b0;
        end
    endtask

    task automatic finish_req(input string tag);
        int cyc;
        cyc = 0;
        while (!(bus.ready_out && bus.pos_empty_out && bus.neigh_empty_out) && cyc < TMO) begin
            @(negedge clk_in);
            cyc++;
        end
        chk({tag, "_done"}, 32'(cyc < TMO), 32'd1);
        chk({tag, "_npos"}, 32'(got_pos.size()), 32'(exp_pos.size()));
        foreach (exp_pos[i]) begin
            if (i < got_pos.size()) chk({tag, "_pos"}, got_pos[i], exp_pos[i]);
        end
        chk({tag, "_nneigh"}, 32'(got_neigh.size()), 32'(exp_neigh.size()));
        foreach (exp_neigh[i]) begin
            if (i < got_neigh.size()) chk({tag, "_neigh"}, got_neigh[i], exp_neigh[i]);
        end
        chk({tag, "_areqs"}, 32'(a_reqs - a0), 32'(DIM));
        chk({tag, "_breqs"}, 32'(b_reqs - b0), 32'(1 + exp_n));
    endtask

    initial begin
        logic [9:0]  idx;
        logic [31:0] w;
        int          n;
        rst_in        = 1'b1;
        bus.valid_in  = 1'b0;
        bus.v_addr_in = '0;
        pos_pop_rand  = 1'b1;
        pos_pop_once  = 0;
        foreach (gmem[i]) gmem[i] = '0;
        foreach (mvis[i]) mvis[i] = 1'b0;
        gmem[1] = 32'd10; gmem[2] = 32'd11; gmem[3] = 32'd12; gmem[4] = 32'd13;
        gmem[5] = 32'd2;  gmem[6] = 32'd55; gmem[7] = 32'd64;
        gmem[55] = 32'd20; gmem[56] = 32'd21; gmem[57] = 32'd22; gmem[58] = 32'd23;
        gmem[59] = 32'd2;  gmem[60] = 32'd1;  gmem[61] = 32'd64;
        gmem[64] = 32'd30; gmem[65] = 32'd31; gmem[66] = 32'd32; gmem[67] = 32'd33;
        gmem[68] = 32'd0;

        repeat (4) @(negedge clk_in);
        check_reset("rst");
        rst_in = 1'b0;
        @(negedge clk_in);
        check_reset("post_rst");

        start_req(32'd1, 1'b0);
        finish_req("s1");
        start_req(32'd55, 1'b0);
        finish_req("s2");
        start_req(32'd64, 1'b0);
        finish_req("s3");

        // Position FIFO held full with no dequeues: port A must stall at FIFO_DEPTH.
        pos_pop_rand = 1'b0;
        start_req(32'd1, 1'b0);
        repeat (20) @(negedge clk_in);
        chk("s4_full", 32'(bus.pos_full_out), 32'd1);
        chk("s4_stall_areqs", 32'(a_reqs - a0), 32'(DEPTH));
        pos_pop_once = 1;
        repeat (15) @(negedge clk_in);
        chk("s4_resume_areqs", 32'(a_reqs - a0), 32'(DEPTH + 1));
        chk("s4_full_again", 32'(bus.pos_full_out), 32'd1);
        pos_pop_rand = 1'b1;
        finish_req("s4");

        start_req(32'd64, 1'b1);
        finish_req("s5");

        // Reset in the middle of a fetch, then repeat the first request from scratch.
        start_req(32'd1, 1'b0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check_reset("s6_rst");
        rst_in = 1'b0;
        foreach (mvis[i]) mvis[i] = 1'b0;
        repeat (6) @(negedge clk_in);
        start_req(32'd1, 1'b0);
        finish_req("s6");
        chk("s6_first_neigh", (got_neigh.size() > 0) ? got_neigh[0] : 32'd0, 32'd55);

        // Random graph: 8 vertices at stride 12, aliased/duplicate neighbour addresses.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < int'(DIM); k++) begin
                idx = 10'(100 + i * 12 + k);
                gmem[idx] = $urandom;
            end
            n = int'($urandom_range(0, 5));
            idx = 10'(100 + i * 12 + int'(DIM));
            gmem[idx] = 32'(n);
            for (int j = 1; j <= n; j++) begin
                case ($urandom_range(0, 2))
                    0:       w = 32'(100 + 12 * $urandom_range(0, 7));
                    1:       w = 32'($urandom_range(0, 1023));
                    default: w = gmem[idx + 10'(j - 1)];
                endcase
                gmem[idx + 10'(j)] = w;
            end
        end
        for (int r = 0; r < 14; r++) begin
            start_req(32'(100 + 12 * $urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            finish_req("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
